apb_mem_slave: RTL and testbench

Parametrised APB4 memory-mapped slave: a word-organised RAM with configurable data width, depth and wait states, byte-lane write strobes and error signalling for out-of-range addresses. It replaces the fixed 8-bit, 64-entry APB memory slave as the standard RAM target behind the APB bridge. Any number of instances can hang off one APB decoder, each with its own psel.

---
 rtl/apb_mem_slave.sv | 150 +++++++++++++++
 tb/tb_apb_mem_slave.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
// APB4 RAM target: word-organised memory with byte-lane write strobes,
// programmable wait states and pslverr for addresses beyond DEPTH.
//
// Ports
//   pclk     in   clock, rising edge
//   preset   in   asynchronous active-high reset
//   psel     in   slave select
//   penable  in   access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address [ADDR_WIDTH]
//   pwdata   in   write data [DATA_WIDTH]
//   pstrb    in   write byte enables [DATA_WIDTH/8]
//   prdata   out  registered read data
//   pready   out  registered transfer completion
//   pslverr  out  registered error, meaningful while pready=1
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no transfer; setup phase loads the wait counter
// S_WAIT  | access phase, counting down wait states, pready=0
// S_READY | pready=1, response loaded; completes on psel&penable
// ---------------------------------------------------------------------------
module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2^ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic                    r_pready;
    logic                    r_pslverr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   w_index;
    logic [MEM_AW-1:0]       w_mem_idx;
    logic                    w_oor;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_setup;
    logic                    w_enter_ready;
    logic                    w_leave_ready;
    logic                    w_we;

    assign w_index   = paddr >> LSB;
    assign w_oor     = ({1'b0, w_index} >= DEPTH_W);
    assign w_mem_idx = w_index[MEM_AW-1:0];
    assign w_rdata   = r_mem[w_mem_idx];

    assign w_setup       = (r_state == S_IDLE) && psel && !penable;
    // READY is reached either straight from setup (no wait states) or on
    // the last wait cycle, provided the master has not dropped psel.
    assign w_enter_ready = (w_setup && (WAIT_STATES == 0)) ||
                           ((r_state == S_WAIT) && psel && (r_cnt == 4'd1));
    assign w_leave_ready = (r_state == S_READY) && (!psel || penable);
    assign w_we          = (r_state == S_READY) && psel && penable &&
                           pwrite && !w_oor;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_cnt   <= WS_LOAD;
                        r_state <= (WAIT_STATES == 0) ? S_READY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!psel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state <= S_READY;
                        end
                    end
                end
                S_READY: begin
                    if (w_leave_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_enter_ready) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_oor;
                if (w_oor) begin
                    r_prdata <= '0;
                end else if (!pwrite) begin
                    r_prdata <= w_rdata;
                end
            end else if (w_leave_ready) begin
                r_pready  <= 1'b0;
                r_pslverr <= 1'b0;
            end
        end
    end

    // Storage has no reset; writes commit only on the completing edge.
    always_ff @(posedge pclk) begin
        if (w_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (pstrb[i]) begin
                    r_mem[w_mem_idx][i*8 +: 8] <= pwdata[i*8 +: 8];
                end
            end
        end
    end

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

    localparam int DEPTH = 48;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel0, psel3, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    int cur;     // 0 -> zero-wait instance, 1 -> three-wait instance
    int n_cmp;
    int n_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem [2][DEPTH];
    logic [31:0] m_prd [2];

    always #5 pclk = ~pclk;

    apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    wire [31:0] w_prdata  = (cur == 1) ? prdata3  : prdata0;
    wire        w_pready  = (cur == 1) ? pready3  : pready0;
    wire        w_pslverr = (cur == 1) ? pslverr3 : pslverr0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(negedge pclk);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    // One full transfer on instance d; expectation is pushed when driven
    // and popped when pready is seen.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input string tag);
        exp_t e;
        int   cyc;
        int   idx;
        bit   oor;
        idx   = int'(a) >> 2;
        oor   = (idx >= DEPTH);
        e.err = oor;
        e.cyc = (d == 1) ? 4 : 1;
        if (wr) e.rdata = m_prd[d];
        else    e.rdata = oor ? 32'h0 : m_mem[d][idx];
        sb.push_back(e);
        if (!wr || oor) m_prd[d] = e.rdata;
        if (wr && !oor) begin
            for (int i = 0; i < 4; i++)
                if (st[i]) m_mem[d][idx][i*8 +: 8] = wd[i*8 +: 8];
        end

        @(negedge pclk);
        check({tag, "_pready_clear"}, {31'b0, w_pready}, 32'h0);
        cur = d;
        psel0 = (d == 0); psel3 = (d == 1);
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(negedge pclk);
        penable = 1'b1;
        cyc = 1;
        while (!w_pready && cyc < 20) begin
            @(negedge pclk);
            cyc++;
        end
        e = sb.pop_front();
        check({tag, "_cycles"}, 32'(cyc), 32'(e.cyc));
        check({tag, "_pslverr"}, {31'b0, w_pslverr}, {31'b0, e.err});
        check({tag, "_prdata"}, w_prdata, e.rdata);
    endtask

    initial begin
        int seen;
        n_cmp = 0; n_err = 0; cur = 0;
        preset = 1'b1; psel0 = 0; psel3 = 0; penable = 0; pwrite = 0;
        paddr = 0; pwdata = 0; pstrb = 0;
        m_prd[0] = 0; m_prd[1] = 0;
        repeat (3) @(negedge pclk);
        check("rst_pready0",  {31'b0, pready0},  32'h0);
        check("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
        check("rst_prdata0",  prdata0,           32'h0);
        check("rst_pready3",  {31'b0, pready3},  32'h0);
        check("rst_prdata3",  prdata3,           32'h0);
        preset = 1'b0;

        // zero wait states, full-word and strobed writes
        xfer(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, "w0_full");
        xfer(0, 0, 8'h10, 32'h0, 4'h0, "r0_full");
        xfer(0, 1, 8'h10, 32'h11223344, 4'b0101, "w0_strb");
        xfer(0, 0, 8'h10, 32'h0, 4'h0, "r0_strb");
        check("strb_value", m_mem[0][4], 32'hDE22BE44);
        xfer(0, 0, 8'h13, 32'h0, 4'h0, "r0_off3");

        // three wait states, back-to-back
        xfer(1, 1, 8'h10, 32'hDEADBEEF, 4'hF, "w3");
        xfer(1, 0, 8'h10, 32'h0, 4'h0, "r3_a");
        xfer(1, 0, 8'h10, 32'h0, 4'h0, "r3_b");

        // reset during WAIT of a write
        @(negedge pclk);
        cur = 1; psel0 = 0; psel3 = 1; penable = 0;
        pwrite = 1; paddr = 8'h10; pwdata = 32'h12345678; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1;
        @(negedge pclk);
        #1 preset = 1'b1;
        #1;
        check("midrst_pready",  {31'b0, pready3},  32'h0);
        check("midrst_pslverr", {31'b0, pslverr3}, 32'h0);
        check("midrst_prdata",  prdata3,           32'h0);
        m_prd[0] = 0; m_prd[1] = 0;
        @(negedge pclk);
        preset = 1'b0; psel3 = 0; penable = 0;
        xfer(1, 0, 8'h10, 32'h0, 4'h0, "r3_after_rst");

        // fill, out-of-range, readback
        for (int i = 0; i < DEPTH; i++)
            xfer(0, 1, 8'(i * 4), 32'(i), 4'hF, "fill");
        xfer(0, 1, 8'hC0, 32'hCAFEF00D, 4'hF, "w_oor");
        xfer(0, 0, 8'hC0, 32'h0, 4'h0, "r_oor");
        xfer(0, 1, 8'hFC, 32'hCAFEF00D, 4'hF, "w_oor_top");
        for (int i = 0; i < DEPTH; i++)
            xfer(0, 0, 8'(i * 4), 32'h0, 4'h0, "readback");

        // abort during WAIT
        xfer(1, 1, 8'h20, 32'hA5A5A5A5, 4'hF, "w3_pre_abort");
        @(negedge pclk);
        cur = 1; psel3 = 1; penable = 0;
        pwrite = 1; paddr = 8'h20; pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1;
        seen = int'(pready3);
        @(negedge pclk);
        seen |= int'(pready3);
        psel3 = 0; penable = 0;
        repeat (6) begin
            @(negedge pclk);
            seen |= int'(pready3);
        end
        check("abort_no_pready", 32'(seen), 32'h0);
        xfer(1, 0, 8'h20, 32'h0, 4'h0, "r3_after_abort");
        idle();
        repeat (2) @(negedge pclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
